// File: rtl/encoder_pkg.sv
// encoder_pkg: shared sizes and FSM state type for the request encoder.
package encoder_pkg;
    localparam int N_REQ = 4;
    localparam int IDX_W = 2;
    typedef enum logic {ST_IDLE, ST_HOLD} state_t;
endpackage

// File: rtl/prio_sel4.sv
// prio_sel4: picks the first set candidate searching base-1, base-2, base-3, base (mod 4).
module prio_sel4
    import encoder_pkg::*;
(
    input  logic [N_REQ-1:0] cand,
    input  logic [IDX_W-1:0] base,
    output logic [IDX_W-1:0] idx,
    output logic             found
);
    logic [IDX_W-1:0] p;
    always_comb begin
        idx   = '0;
        found = 1'b0;
        p     = '0;
        // Walk lowest priority first so the highest-priority hit is written last.
        for (int k = N_REQ; k >= 1; k--) begin
            p = base - IDX_W'(k);
            if (cand[p]) begin
                idx   = p;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/encoder4x2_ctrl.sv
// encoder4x2_ctrl: registered 4:2 request encoder with pending capture and valid/ack handshake.
// Define ROUND_ROBIN_EN for rotating priority; otherwise I3 has fixed highest priority.
module encoder4x2_ctrl
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             I0,
    input  logic             I1,
    input  logic             I2,
    input  logic             I3,
    input  logic             ack,
    output logic             a,
    output logic             b,
    output logic             valid,
    output logic [N_REQ-1:0] pend
);
    state_t           state, state_next;
    logic [N_REQ-1:0] cand, clear;
    logic [IDX_W-1:0] sel, base;
    logic             found, load;

    assign cand  = pend | (en ? {I3, I2, I1, I0} : '0);
    assign load  = found & ((state == ST_IDLE) | ack);
    assign clear = load ? (N_REQ'(1) << sel) : '0;

    prio_sel4 u_sel (
        .cand  (cand),
        .base  (base),
        .idx   (sel),
        .found (found)
    );

`ifdef ROUND_ROBIN_EN
    logic [IDX_W-1:0] last;
    always_ff @(posedge clk) begin
        if (!rst_n)
            last <= '0;
        else if (load)
            last <= sel;
    end
    assign base = last;
`else
    assign base = '0;
`endif

    always_ff @(posedge clk) begin
        state <= !rst_n ? ST_IDLE : state_next;
    end

    always_comb begin
        state_next = (state == ST_IDLE || ack) ? (found ? ST_HOLD : ST_IDLE) : ST_HOLD;
    end

    always_comb begin
        valid = (state == ST_HOLD);
    end

    // The held index is only replaced on a load, so a/b keep their value after draining to IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend   <= '0;
            {b, a} <= '0;
        end else begin
            pend <= cand & ~clear;
            if (load)
                {b, a} <= sel;
        end
    end
endmodule
